alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one ArithmeticLogicUnit instance between two requesters (req0 = execute stage, req1 = address/branch-compare helper).
- Round-robin arbitration; one operation in flight at a time.
- Registers the operands into the ALU, captures its result/zero flag, and returns them tagged with the requester ID over a valid/ready response channel.
- Includes a watchdog that terminates an operation with an error if the ALU never asserts result-valid.

Parameters:
- XLEN, 32, operand/result width.
- TIMEOUT, 15, ISSUE-state cycles without i_alu_f_valid before the operation is aborted (1..255).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- i_req0_valid  input  1  requester 0 operation valid
- o_req0_ready  output  1  requester 0 accepted
- i_req0_op  input  4  requester 0 ALU opcode
- i_req0_a  input  XLEN  requester 0 operand A
- i_req0_b  input  XLEN  requester 0 operand B
- i_req1_valid, o_req1_ready, i_req1_op, i_req1_a, i_req1_b  same as req0, requester 1
- o_alu_op_valid  output  1  opcode valid to ALU
- i_alu_op_ready  input  1  ALU opcode ready
- o_alu_op_data  output  4  opcode to ALU
- o_alu_a_valid  output  1  operand A valid
- o_alu_a_data  output  XLEN  operand A
- o_alu_b_valid  output  1  operand B valid
- o_alu_b_data  output  XLEN  operand B
- i_alu_f_valid  input  1  ALU result valid
- i_alu_f_data  input  XLEN  ALU result
- i_alu_z_valid  input  1  ALU result-is-zero flag
- o_rsp_valid  output  1  response valid
- i_rsp_ready  input  1  response accepted
- o_rsp_id  output  1  requester that owns the response
- o_rsp_data  output  XLEN  captured result (0 on error)
- o_rsp_zero  output  1  captured zero flag (0 on error)
- o_rsp_err  output  1  watchdog timeout

Behaviour:
- Reset (async assert, sync deassert usage):
  - state = IDLE; RR pointer = 0; watchdog = 0.
  - All registered outputs 0: o_rsp_*, o_alu_op_data, o_alu_a_data, o_alu_b_data.
  - o_alu_*_valid = 0; o_reqN_ready = 0.
  - Reset mid-operation discards the in-flight op; no response is produced.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Grant = pointer requester if its valid is high, else the other requester if its valid is high.
  - o_reqN_ready = (state==IDLE) & grantN, combinational from the valids.
  - On grant: capture op/a/b/ID into issue registers; go to ISSUE next cycle.
  - No valid: stay in IDLE.
  - A requester must hold valid and payload stable until it sees ready.
- ISSUE:
  - o_alu_op_valid = o_alu_a_valid = o_alu_b_valid = 1; data driven from the issue registers (stable for the whole state).
  - On i_alu_op_ready & i_alu_f_valid: capture i_alu_f_data → o_rsp_data and i_alu_z_valid → o_rsp_zero; o_rsp_err = 0; go to RESP.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1 without a capture: o_rsp_data = 0, o_rsp_zero = 0, o_rsp_err = 1; go to RESP.
  - The watchdog clears on entry to ISSUE.
- RESP:
  - o_rsp_valid = 1, o_rsp_id = captured ID; all response fields stable until handshake.
  - On i_rsp_ready: go to IDLE; pointer = ~ID; o_rsp_valid drops next cycle.
  - No new request is accepted in the same cycle as the response handshake.
- Latency and throughput:
  - Request accept cycle T → ALU drive at T+1 → o_rsp_valid at T+2 with a single-cycle ALU and immediate rsp ready.
  - Peak throughput: one op per 3 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Opcodes pass through unmodified; opcode legality is the ALU's concern.
- A failed or timed-out op does not alter the RR rule: the pointer still moves to ~ID.

Test Plan:
- Reset, then req0 only, op=ADD, a=5, b=7 → o_req0_ready at cycle T; o_alu_op_valid at T+1 with a=5, b=7; o_rsp_valid at T+2 with id=0, data=12, zero=0, err=0.
- req0 and req1 both valid from reset, all ops SUB 3-3 → grant order 0,1,0,1; every response has data=0, zero=1.
- Response backpressure: hold i_rsp_ready=0 for 6 cycles with req1 pending → o_rsp_* stable; o_req1_ready stays 0 until 1 cycle after the handshake.
- Timeout: i_alu_f_valid held 0 with TIMEOUT=15 → exactly 15 ISSUE cycles, then o_rsp_valid with err=1, data=0; the next op completes normally with err=0.
- Assert rstn low during ISSUE, then release → all outputs 0, state IDLE, no stray o_rsp_valid; next request is granted to req0 when both requesters are valid.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters, with a
// result-valid watchdog and a requester-tagged valid/ready response channel.
module alu_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_req0_valid,
    output logic            o_req0_ready,
    input  logic [3:0]      i_req0_op,
    input  logic [XLEN-1:0] i_req0_a,
    input  logic [XLEN-1:0] i_req0_b,
    input  logic            i_req1_valid,
    output logic            o_req1_ready,
    input  logic [3:0]      i_req1_op,
    input  logic [XLEN-1:0] i_req1_a,
    input  logic [XLEN-1:0] i_req1_b,
    output logic            o_alu_op_valid,
    input  logic            i_alu_op_ready,
    output logic [3:0]      o_alu_op_data,
    output logic            o_alu_a_valid,
    output logic [XLEN-1:0] o_alu_a_data,
    output logic            o_alu_b_valid,
    output logic [XLEN-1:0] o_alu_b_data,
    input  logic            i_alu_f_valid,
    input  logic [XLEN-1:0] i_alu_f_data,
    input  logic            i_alu_z_valid,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic            o_rsp_id,
    output logic [XLEN-1:0] o_rsp_data,
    output logic            o_rsp_zero,
    output logic            o_rsp_err
);
    localparam int unsigned     WD_W    = 8;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            rr_ptr;
    logic            issue_id;
    logic            alu_vld;
    logic [WD_W-1:0] wd_cnt;
    logic            grant0;
    logic            grant1;
    logic            grant_any;
    logic            alu_done;
    logic            wd_expired;
    logic            rsp_fire;

    // Grant and next-state decode; ready is held low while reset is asserted.
    always_comb begin
        state_nxt  = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        alu_done   = 1'b0;
        wd_expired = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rstn) begin
                    if (!rr_ptr) begin
                        grant0 = i_req0_valid;
                        grant1 = i_req1_valid & ~i_req0_valid;
                    end else begin
                        grant1 = i_req1_valid;
                        grant0 = i_req0_valid & ~i_req1_valid;
                    end
                end
                if (grant0 | grant1) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_done   = i_alu_op_ready & i_alu_f_valid;
                wd_expired = ~alu_done & (wd_cnt == WD_LAST);
                if (alu_done | wd_expired) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_fire = i_rsp_ready;
                if (i_rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign grant_any      = grant0 | grant1;
    assign o_req0_ready   = grant0;
    assign o_req1_ready   = grant1;
    assign o_alu_op_valid = alu_vld;
    assign o_alu_a_valid  = alu_vld;
    assign o_alu_b_valid  = alu_vld;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue registers, watchdog, response capture and round-robin pointer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr        <= 1'b0;
            issue_id      <= 1'b0;
            alu_vld       <= 1'b0;
            wd_cnt        <= '0;
            o_alu_op_data <= '0;
            o_alu_a_data  <= '0;
            o_alu_b_data  <= '0;
            o_rsp_valid   <= 1'b0;
            o_rsp_id      <= 1'b0;
            o_rsp_data    <= '0;
            o_rsp_zero    <= 1'b0;
            o_rsp_err     <= 1'b0;
        end else begin
            if (grant_any) begin
                alu_vld       <= 1'b1;
                issue_id      <= grant1;
                wd_cnt        <= '0;
                o_alu_op_data <= grant1 ? i_req1_op : i_req0_op;
                o_alu_a_data  <= grant1 ? i_req1_a  : i_req0_a;
                o_alu_b_data  <= grant1 ? i_req1_b  : i_req0_b;
            end
            if (alu_done | wd_expired) begin
                alu_vld     <= 1'b0;
                o_rsp_valid <= 1'b1;
                o_rsp_id    <= issue_id;
                o_rsp_data  <= alu_done ? i_alu_f_data : '0;
                o_rsp_zero  <= alu_done & i_alu_z_valid;
                o_rsp_err   <= wd_expired;
            end else if (state == ST_ISSUE) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (rsp_fire) begin
                o_rsp_valid <= 1'b0;
                rr_ptr      <= ~o_rsp_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: queued requesters, a latency-programmable
// ALU responder and a negedge monitor checked against an arbitration model.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 15;
    localparam int          DEAD    = 1000;

    typedef struct {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        int              lat;
        int              rlat;
    } req_t;

    typedef struct {
        logic            id;
        logic [XLEN-1:0] data;
        logic            zero;
        logic            err;
        int              cycles;
        int              acc_cyc;
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
    } exp_t;

    logic            clk;
    logic            rstn;
    logic            i_req0_valid, o_req0_ready, i_req1_valid, o_req1_ready;
    logic [3:0]      i_req0_op, i_req1_op, o_alu_op_data;
    logic [XLEN-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic            o_alu_op_valid, i_alu_op_ready, o_alu_a_valid, o_alu_b_valid;
    logic [XLEN-1:0] o_alu_a_data, o_alu_b_data, i_alu_f_data, o_rsp_data;
    logic            i_alu_f_valid, i_alu_z_valid;
    logic            o_rsp_valid, i_rsp_ready, o_rsp_id, o_rsp_zero, o_rsp_err;

    alu_arbiter #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_op(i_req0_op),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_op(i_req1_op),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
        .o_alu_op_valid(o_alu_op_valid), .i_alu_op_ready(i_alu_op_ready),
        .o_alu_op_data(o_alu_op_data), .o_alu_a_valid(o_alu_a_valid),
        .o_alu_a_data(o_alu_a_data), .o_alu_b_valid(o_alu_b_valid),
        .o_alu_b_data(o_alu_b_data), .i_alu_f_valid(i_alu_f_valid),
        .i_alu_f_data(i_alu_f_data), .i_alu_z_valid(i_alu_z_valid),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
        .o_rsp_data(o_rsp_data), .o_rsp_zero(o_rsp_zero), .o_rsp_err(o_rsp_err)
    );

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];
    int   glog[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic ptr = 1'b0;
    int   outstanding = 0;
    bit   acc0 = 0, acc1 = 0;
    int   hold0 = 0, hold1 = 0;
    bit   gap_en = 0, rsp_hold = 0, rsp_rand = 0, log_en = 0;
    int   lat0 = 0, rlat0 = 0, lat1 = 0, rlat1 = 0;
    int   cur_lat = 0, cur_rlat = 0;
    int   issue_cnt = 0;
    bit   rsp_seen = 0;
    int   alu_idx = 0;
    bit   alu_prev = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            default: return ~a;
        endcase
    endfunction

    task automatic push(input int who, input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int lat, input int rlat);
        req_t r;
        r.op = op; r.a = a; r.b = b; r.lat = lat; r.rlat = rlat;
        if (who == 0) q0.push_back(r);
        else q1.push_back(r);
    endtask

    // Requester drivers and response-ready generator.
    always @(posedge clk) begin
        #1;
        if (acc0) begin void'(q0.pop_front()); acc0 = 0; hold0 = gap_en ? $urandom_range(0, 2) : 0; end
        if (acc1) begin void'(q1.pop_front()); acc1 = 0; hold1 = gap_en ? $urandom_range(0, 2) : 0; end
        if (hold0 > 0) begin hold0--; i_req0_valid = 1'b0; end
        else if (q0.size() > 0) begin
            i_req0_valid = 1'b1; i_req0_op = q0[0].op; i_req0_a = q0[0].a; i_req0_b = q0[0].b;
            lat0 = q0[0].lat; rlat0 = q0[0].rlat;
        end else begin
            i_req0_valid = 1'b0; i_req0_op = 4'($urandom); i_req0_a = $urandom; i_req0_b = $urandom;
        end
        if (hold1 > 0) begin hold1--; i_req1_valid = 1'b0; end
        else if (q1.size() > 0) begin
            i_req1_valid = 1'b1; i_req1_op = q1[0].op; i_req1_a = q1[0].a; i_req1_b = q1[0].b;
            lat1 = q1[0].lat; rlat1 = q1[0].rlat;
        end else begin
            i_req1_valid = 1'b0; i_req1_op = 4'($urandom); i_req1_a = $urandom; i_req1_b = $urandom;
        end
        if (rsp_hold) i_rsp_ready = 1'b0;
        else if (rsp_rand) i_rsp_ready = 1'($urandom % 2);
        else i_rsp_ready = 1'b1;
    end

    // ALU responder: result after cur_lat issue cycles, op_ready after cur_rlat.
    always @(posedge clk) begin
        logic [XLEN-1:0] res;
        #1;
        if (o_alu_op_valid) begin
            alu_idx = alu_prev ? alu_idx + 1 : 0;
            alu_prev = 1;
            res = ref_alu(o_alu_op_data, o_alu_a_data, o_alu_b_data);
            i_alu_f_valid  = (alu_idx >= cur_lat);
            i_alu_op_ready = (alu_idx >= cur_rlat);
            i_alu_f_data   = i_alu_f_valid ? res : $urandom;
            i_alu_z_valid  = i_alu_f_valid ? (res == '0) : 1'($urandom % 2);
        end else begin
            alu_prev = 0;
            i_alu_f_valid  = 1'b0;
            i_alu_op_ready = 1'($urandom % 2);
            i_alu_f_data   = $urandom;
            i_alu_z_valid  = 1'($urandom % 2);
        end
    end

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic er0, er1;
        exp_t e;
        int   m;
        cyc++;
        if (!rstn) begin
            chk("reset_outputs", 64'(|{o_req0_ready, o_req1_ready, o_alu_op_valid, o_alu_a_valid,
                o_alu_b_valid, o_alu_op_data, o_alu_a_data, o_alu_b_data, o_rsp_valid, o_rsp_id,
                o_rsp_data, o_rsp_zero, o_rsp_err}), 64'd0);
            sb.delete();
            outstanding = 0; ptr = 1'b0; acc0 = 0; acc1 = 0;
        end else begin
            er0 = (outstanding == 0) && (ptr == 1'b0 ? i_req0_valid : (i_req0_valid && !i_req1_valid));
            er1 = (outstanding == 0) && (ptr == 1'b1 ? i_req1_valid : (i_req1_valid && !i_req0_valid));
            chk("ready_grant", {o_req0_ready, o_req1_ready}, {er0, er1});
            acc0 = i_req0_valid && o_req0_ready;
            acc1 = i_req1_valid && o_req1_ready;
            if (acc0 || acc1) begin
                e.id = acc1;
                e.op = acc1 ? i_req1_op : i_req0_op;
                e.a  = acc1 ? i_req1_a : i_req0_a;
                e.b  = acc1 ? i_req1_b : i_req0_b;
                cur_lat  = acc1 ? lat1 : lat0;
                cur_rlat = acc1 ? rlat1 : rlat0;
                m = (cur_lat > cur_rlat) ? cur_lat : cur_rlat;
                e.err    = (m > int'(TIMEOUT) - 1);
                e.cycles = e.err ? int'(TIMEOUT) : m + 1;
                e.data   = e.err ? '0 : ref_alu(e.op, e.a, e.b);
                e.zero   = !e.err && (e.data == '0);
                e.acc_cyc = cyc;
                sb.push_back(e);
                outstanding++;
                issue_cnt = 0;
                rsp_seen = 0;
                if (log_en) glog.push_back(int'(e.id));
            end
            if (o_alu_op_valid) begin
                issue_cnt++;
                chk("alu_has_owner", 64'(outstanding), 64'd1);
                if (sb.size() > 0) begin
                    chk("alu_op", o_alu_op_data, sb[0].op);
                    chk("alu_a", o_alu_a_data, sb[0].a);
                    chk("alu_b", o_alu_b_data, sb[0].b);
                    chk("alu_ab_valid", {o_alu_a_valid, o_alu_b_valid}, 2'b11);
                    if (issue_cnt == 1) chk("issue_latency", 64'(cyc), 64'(sb[0].acc_cyc + 1));
                end
            end
            if (o_rsp_valid) begin
                chk("rsp_has_owner", 64'(outstanding), 64'd1);
                if (sb.size() > 0) begin
                    chk("rsp_id", o_rsp_id, sb[0].id);
                    chk("rsp_data", o_rsp_data, sb[0].data);
                    chk("rsp_zero", o_rsp_zero, sb[0].zero);
                    chk("rsp_err", o_rsp_err, sb[0].err);
                    if (!rsp_seen) begin
                        rsp_seen = 1;
                        chk("issue_cycles", 64'(issue_cnt), 64'(sb[0].cycles));
                        chk("rsp_latency", 64'(cyc), 64'(sb[0].acc_cyc + sb[0].cycles + 1));
                    end
                    if (i_rsp_ready) begin
                        ptr = ~sb[0].id;
                        void'(sb.pop_front());
                        outstanding--;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || outstanding != 0 || o_rsp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_budget", 64'(n >= budget), 64'd0);
    endtask

    task automatic wait_sig(input bit alu, input int budget);
        int n = 0;
        while (!(alu ? o_alu_op_valid : o_rsp_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(alu ? "alu_start_in_budget" : "rsp_start_in_budget", 64'(n >= budget), 64'd0);
    endtask

    initial begin
        logic [XLEN-1:0] ra, rb;
        int l, r;
        rstn = 1'b1;
        i_req0_valid = 1'b0; i_req1_valid = 1'b0; i_rsp_ready = 1'b1;
        i_req0_op = '0; i_req0_a = '0; i_req0_b = '0;
        i_req1_op = '0; i_req1_a = '0; i_req1_b = '0;
        i_alu_op_ready = 1'b0; i_alu_f_valid = 1'b0; i_alu_f_data = '0; i_alu_z_valid = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        // Single ADD 5+7 on requester 0.
        @(posedge clk);
        push(0, 4'd0, 32'd5, 32'd7, 0, 0);
        wait_idle(100);

        // Both requesters valid straight out of reset: strict alternation.
        @(posedge clk);
        #2 rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(0, 4'd1, 32'd3, 32'd3, 0, 0);
            push(1, 4'd1, 32'd3, 32'd3, 0, 0);
        end
        glog.delete();
        log_en = 1;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        wait_idle(200);
        log_en = 0;
        chk("rr_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < glog.size(); i++) chk("rr_order", 64'(glog[i]), 64'(i % 2));

        // Response backpressure with requester 1 pending.
        @(posedge clk);
        rsp_hold = 1;
        push(0, 4'd4, $urandom, $urandom, 0, 0);
        push(1, 4'd2, $urandom, $urandom, 0, 0);
        wait_sig(0, 50);
        repeat (6) @(posedge clk);
        rsp_hold = 0;
        wait_idle(100);

        // Watchdog timeout followed by a normal op, then boundary latencies.
        @(posedge clk);
        push(0, 4'd0, $urandom, $urandom, DEAD, 0);
        push(0, 4'd3, $urandom, $urandom, 0, 0);
        push(1, 4'd0, $urandom, $urandom, int'(TIMEOUT) - 1, 0);
        push(1, 4'd1, $urandom, $urandom, int'(TIMEOUT), 0);
        push(0, 4'd2, $urandom, $urandom, 0, 3);
        push(0, 4'd4, $urandom, $urandom, 2, int'(TIMEOUT) - 1);
        wait_idle(400);

        // Randomised traffic with gaps, stalls, timeouts and rsp backpressure.
        @(posedge clk);
        gap_en = 1; rsp_rand = 1;
        for (int i = 0; i < 30; i++) begin
            for (int w = 0; w < 2; w++) begin
                ra = $urandom;
                rb = ($urandom % 4 == 0) ? ra : $urandom;
                l = ($urandom % 10 == 0) ? DEAD : $urandom_range(0, 4);
                r = $urandom_range(0, 3);
                push(w, 4'($urandom_range(0, 9)), ra, rb, l, r);
            end
        end
        wait_idle(5000);
        gap_en = 0; rsp_rand = 0;

        // Reset during ISSUE: in-flight op vanishes, pointer returns to 0.
        @(posedge clk);
        push(0, 4'd0, 32'd1, 32'd1, 0, 0);
        wait_idle(100);
        @(posedge clk);
        push(1, 4'd0, 32'd1, 32'd2, DEAD, 0);
        wait_sig(1, 50);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        repeat (4) @(posedge clk);
        glog.delete();
        log_en = 1;
        push(0, 4'd6, 32'hF0, 32'd4, 0, 0);
        push(1, 4'd5, 32'h1, 32'd8, 0, 0);
        wait_idle(100);
        log_en = 0;
        chk("post_reset_count", 64'(glog.size()), 64'd2);
        if (glog.size() > 0) chk("post_reset_first_grant", 64'(glog[0]), 64'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("FAIL global_timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
